// File: rtl/alu_exec_ctrl.sv
// alu_exec_ctrl: accepts one ALU instruction at a time and drives registered
// operands to an external combinational ALU. It writes the ALU result back
// into a four-entry register file and pulses done for one cycle.
// Each instruction passes through three states: IDLE -> EXEC -> DONE -> IDLE.
// Optional feature: define ALU_EXEC_FLAGS_EN to track the zero and negative
// flags of the last written result. Without it, flag_z and flag_n read 0.

// One general register. It resets to RESET_VAL and loads d when we is high.
module alu_exec_reg #(
    parameter logic [7:0] RESET_VAL = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       we,
    input  logic [7:0] d,
    output logic [7:0] q
);

    // Reset has priority, so a writeback that collides with reset is dropped.
    always_ff @(posedge clk) begin
        if (rst)     q <= RESET_VAL;
        else if (we) q <= d;
    end

endmodule

module alu_exec_ctrl #(
    parameter logic [7:0] REG_RESET_VAL = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       instr_valid,
    output logic       instr_ready,
    input  logic [2:0] instr_op,
    input  logic [1:0] instr_rd,
    input  logic [1:0] instr_rs,
    input  logic       instr_imm_sel,
    input  logic [7:0] instr_imm,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic [2:0] alu_op,
    input  logic [7:0] alu_result,
    output logic       done,
    output logic       flag_z,
    output logic       flag_n,
    input  logic [1:0] dbg_sel,
    output logic [7:0] dbg_data
);

    localparam int NUM_REGS = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                        state, state_nxt;
    logic                          accept;
    logic                          wb_en;
    logic [1:0]                    rd_q;
    logic [NUM_REGS-1:0]           reg_we;
    logic [NUM_REGS-1:0][7:0]      regs;

    assign accept = instr_valid && instr_ready;

    // State register. Reset returns to IDLE from any state, including EXEC.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state and handshake outputs. Ready is held low while reset is asserted.
    // done is high for the single DONE cycle that follows the writeback edge.
    always_comb begin
        state_nxt   = state;
        instr_ready = 1'b0;
        done        = 1'b0;
        wb_en       = 1'b0;
        case (state)
            IDLE: begin
                instr_ready = !rst;
                if (instr_valid && !rst) state_nxt = EXEC;
            end
            EXEC: begin
                wb_en     = 1'b1;
                state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Latch the operands, the opcode and the destination register on accept.
    // They hold their values until the next accept.
    // rd and rs read the same pre-write value when they are equal, because the
    // previous writeback has always completed before the next accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_a  <= 8'h00;
            alu_b  <= 8'h00;
            alu_op <= 3'b000;
            rd_q   <= 2'd0;
        end else if (accept) begin
            alu_a  <= regs[instr_rd];
            alu_b  <= instr_imm_sel ? instr_imm : regs[instr_rs];
            alu_op <= instr_op;
            rd_q   <= instr_rd;
        end
    end

    // Decode the writeback enable to the latched destination register.
    always_comb begin
        reg_we = '0;
        if (wb_en) reg_we[rd_q] = 1'b1;
    end

    // Register file: one instance per register.
    // The ALU result is written modulo 256 and the carry is not kept.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            alu_exec_reg #(
                .RESET_VAL (REG_RESET_VAL)
            ) u_reg (
                .clk (clk),
                .rst (rst),
                .we  (reg_we[gi]),
                .d   (alu_result),
                .q   (regs[gi])
            );
        end
    endgenerate

    // Debug port: combinational read, so a write is visible in the cycle after the write edge.
    assign dbg_data = regs[dbg_sel];

`ifdef ALU_EXEC_FLAGS_EN
    // Flags are captured on the writeback edge and held until the next writeback or reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            flag_z <= 1'b0;
            flag_n <= 1'b0;
        end else if (wb_en) begin
            flag_z <= (alu_result == 8'h00);
            flag_n <= alu_result[7];
        end
    end
`else
    assign flag_z = 1'b0;
    assign flag_n = 1'b0;
`endif

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Directed testbench for alu_exec_ctrl. It models the external ALU and drives
// a table of instructions with hand-computed expected results. Hand-written
// sequences then cover two multi-cycle cases: the held-valid/pending handshake
// and a reset asserted while the block is in EXEC.
module tb_alu_exec_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       instr_valid;
    logic       instr_ready;
    logic [2:0] instr_op;
    logic [1:0] instr_rd;
    logic [1:0] instr_rs;
    logic       instr_imm_sel;
    logic [7:0] instr_imm;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [2:0] alu_op;
    logic [7:0] alu_result;
    logic       done;
    logic       flag_z;
    logic       flag_n;
    logic [1:0] dbg_sel;
    logic [7:0] dbg_data;

    int checks = 0;
    int errors = 0;

    alu_exec_ctrl #(.REG_RESET_VAL(8'h00)) dut (
        .clk           (clk),
        .rst           (rst),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr_op      (instr_op),
        .instr_rd      (instr_rd),
        .instr_rs      (instr_rs),
        .instr_imm_sel (instr_imm_sel),
        .instr_imm     (instr_imm),
        .alu_a         (alu_a),
        .alu_b         (alu_b),
        .alu_op        (alu_op),
        .alu_result    (alu_result),
        .done          (done),
        .flag_z        (flag_z),
        .flag_n        (flag_n),
        .dbg_sel       (dbg_sel),
        .dbg_data      (dbg_data)
    );

    always #5 clk = ~clk;

    // Downstream combinational ALU (the environment, not the reference).
    always_comb begin
        alu_result = 8'h00;
        case (alu_op)
            3'd0: alu_result = alu_a + alu_b;
            3'd1: alu_result = alu_a - alu_b;
            3'd2: alu_result = alu_a & alu_b;
            3'd3: alu_result = alu_a | alu_b;
            3'd4: alu_result = alu_a ^ alu_b;
            3'd5: alu_result = ~alu_a;
            3'd6: alu_result = alu_b;
            3'd7: alu_result = alu_a + 8'h01;
            default: alu_result = 8'h00;
        endcase
    end

    typedef struct {
        logic [2:0] op;
        logic [1:0] rd;
        logic [1:0] rs;
        logic       isel;
        logic [7:0] imm;
        logic [7:0] exp_a;
        logic [7:0] exp_b;
        logic [7:0] exp_res;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic read_reg(input logic [1:0] sel, output logic [7:0] val);
        dbg_sel = sel;
        #1;
        val = dbg_data;
    endtask

    task automatic chk_reg(input string name, input logic [1:0] sel, input logic [7:0] exp);
        logic [7:0] v;
        read_reg(sel, v);
        chk(name, v, exp);
    endtask

    // Issue one instruction and check the latched operands, that done pulses
    // exactly once in the DONE cycle, the written value and the flags.
    task automatic run_vec(input int idx, input vec_t v);
        int  waited;
        int  pulses;
        int  pulse_at;
        logic exp_z, exp_n;
        @(negedge clk);
        waited = 0;
        while (!instr_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!instr_ready) begin
            chk($sformatf("v%0d ready timeout", idx), {7'd0, instr_ready}, 8'd1);
            return;
        end
        instr_valid   = 1'b1;
        instr_op      = v.op;
        instr_rd      = v.rd;
        instr_rs      = v.rs;
        instr_imm_sel = v.isel;
        instr_imm     = v.imm;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        chk($sformatf("v%0d alu_a", idx), alu_a, v.exp_a);
        chk($sformatf("v%0d alu_b", idx), alu_b, v.exp_b);
        chk($sformatf("v%0d alu_op", idx), {5'd0, alu_op}, {5'd0, v.op});
        pulses   = 0;
        pulse_at = -1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (done) begin
                pulses++;
                pulse_at = k;
            end
        end
        chk($sformatf("v%0d done pulses", idx), pulses[7:0], 8'd1);
        chk($sformatf("v%0d done cycle", idx), pulse_at[7:0], 8'd1);
        chk_reg($sformatf("v%0d result", idx), v.rd, v.exp_res);
`ifdef ALU_EXEC_FLAGS_EN
        exp_z = (v.exp_res == 8'h00);
        exp_n = v.exp_res[7];
`else
        exp_z = 1'b0;
        exp_n = 1'b0;
`endif
        chk($sformatf("v%0d flag_z", idx), {7'd0, flag_z}, {7'd0, exp_z});
        chk($sformatf("v%0d flag_n", idx), {7'd0, flag_n}, {7'd0, exp_n});
    endtask

    initial begin
        //         op    rd    rs    isel  imm    a      b      result
        vecs[0]  = '{3'd6, 2'd1, 2'd0, 1'b1, 8'h05, 8'h00, 8'h05, 8'h05}; // PASSB r1,#05
        vecs[1]  = '{3'd0, 2'd1, 2'd1, 1'b0, 8'h00, 8'h05, 8'h05, 8'h0A}; // ADD r1,r1
        vecs[2]  = '{3'd1, 2'd2, 2'd0, 1'b1, 8'h01, 8'h00, 8'h01, 8'hFF}; // SUB r2,#01
        vecs[3]  = '{3'd6, 2'd0, 2'd0, 1'b1, 8'hFF, 8'h00, 8'hFF, 8'hFF}; // PASSB r0,#FF
        vecs[4]  = '{3'd7, 2'd0, 2'd0, 1'b0, 8'h00, 8'hFF, 8'hFF, 8'h00}; // INC r0 wraps
        vecs[5]  = '{3'd6, 2'd3, 2'd0, 1'b1, 8'h3C, 8'h00, 8'h3C, 8'h3C}; // PASSB r3,#3C
        vecs[6]  = '{3'd2, 2'd3, 2'd1, 1'b0, 8'h00, 8'h3C, 8'h0A, 8'h08}; // AND r3,r1
        vecs[7]  = '{3'd3, 2'd3, 2'd0, 1'b1, 8'hC1, 8'h08, 8'hC1, 8'hC9}; // OR r3,#C1
        vecs[8]  = '{3'd4, 2'd2, 2'd3, 1'b0, 8'h00, 8'hFF, 8'hC9, 8'h36}; // XOR r2,r3
        vecs[9]  = '{3'd5, 2'd1, 2'd1, 1'b0, 8'h00, 8'h0A, 8'h0A, 8'hF5}; // NOT r1
        vecs[10] = '{3'd0, 2'd1, 2'd0, 1'b1, 8'h0B, 8'hF5, 8'h0B, 8'h00}; // ADD r1,#0B wraps
        vecs[11] = '{3'd6, 2'd0, 2'd0, 1'b1, 8'hA5, 8'h00, 8'hA5, 8'hA5}; // PASSB r0,#A5
        vecs[12] = '{3'd4, 2'd0, 2'd0, 1'b0, 8'h00, 8'hA5, 8'hA5, 8'h00}; // XOR r0,r0

        rst           = 1'b1;
        instr_valid   = 1'b0;
        instr_op      = 3'd0;
        instr_rd      = 2'd0;
        instr_rs      = 2'd0;
        instr_imm_sel = 1'b0;
        instr_imm     = 8'h00;
        dbg_sel       = 2'd0;

        // Reset, then release.
        repeat (3) @(negedge clk);
        chk("ready during rst", {7'd0, instr_ready}, 8'd0);
        rst = 1'b0;
        #1;
        chk("ready after rst", {7'd0, instr_ready}, 8'd1);
        chk("done after rst", {7'd0, done}, 8'd0);
        chk("alu_a rst", alu_a, 8'h00);
        chk("alu_b rst", alu_b, 8'h00);
        chk("alu_op rst", {5'd0, alu_op}, 8'd0);
        chk("flag_z rst", {7'd0, flag_z}, 8'd0);
        chk("flag_n rst", {7'd0, flag_n}, 8'd0);
        for (int r = 0; r < 4; r++) chk_reg($sformatf("r%0d rst", r), r[1:0], 8'h00);

        // Table of instructions. Register state afterwards: r0=00 r1=00 r2=36 r3=C9.
        for (int i = 0; i < 13; i++) run_vec(i, vecs[i]);

        // Hold valid high with a changing payload during EXEC/DONE. Only the
        // accepted instruction runs; the next one is accepted back in IDLE.
        @(negedge clk);
        chk("hold ready idle", {7'd0, instr_ready}, 8'd1);
        instr_valid = 1'b1; instr_op = 3'd6; instr_rd = 2'd1; instr_imm_sel = 1'b1; instr_imm = 8'h11;
        @(posedge clk); #1;
        instr_op = 3'd6; instr_rd = 2'd2; instr_imm_sel = 1'b1; instr_imm = 8'h77;
        @(negedge clk);
        chk("hold exec ready", {7'd0, instr_ready}, 8'd0);
        chk("hold exec done", {7'd0, done}, 8'd0);
        instr_imm = 8'h78;
        @(negedge clk);
        chk("hold done pulse", {7'd0, done}, 8'd1);
        chk("hold ready in done", {7'd0, instr_ready}, 8'd0);
        chk_reg("hold r1 first", 2'd1, 8'h11);
        @(negedge clk);
        chk("hold done low", {7'd0, done}, 8'd0);
        chk("hold ready back", {7'd0, instr_ready}, 8'd1);
        chk_reg("hold r2 untouched", 2'd2, 8'h36);
        instr_op = 3'd0; instr_rd = 2'd1; instr_imm_sel = 1'b1; instr_imm = 8'h22;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        @(negedge clk);
        chk("second exec done", {7'd0, done}, 8'd0);
        @(negedge clk);
        chk("second done 3 apart", {7'd0, done}, 8'd1);
        chk_reg("second r1", 2'd1, 8'h33);
        chk_reg("second r2 untouched", 2'd2, 8'h36);

        // Assert reset while INC r3 is in EXEC.
        @(negedge clk);
        chk_reg("pre inc r3", 2'd3, 8'hC9);
        instr_valid = 1'b1; instr_op = 3'd7; instr_rd = 2'd3; instr_rs = 2'd3; instr_imm_sel = 1'b0;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst exec done", {7'd0, done}, 8'd0);
        chk("rst exec ready", {7'd0, instr_ready}, 8'd0);
        chk("rst exec alu_a", alu_a, 8'h00);
        chk("rst exec alu_op", {5'd0, alu_op}, 8'd0);
        rst = 1'b0;
        #1;
        chk("rst release ready", {7'd0, instr_ready}, 8'd1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("no done after rst %0d", k), {7'd0, done}, 8'd0);
        end
        for (int r = 0; r < 4; r++) chk_reg($sformatf("r%0d post rst", r), r[1:0], 8'h00);
        chk("flag_z post rst", {7'd0, flag_z}, 8'd0);
        chk("flag_n post rst", {7'd0, flag_n}, 8'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Overall time limit so the bench always ends on its own.
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete, errors=%0d of %0d checks", errors, checks);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/alu_exec_ctrl.md
ALU_EXEC_CTRL -- requirements
Module: alu_exec_ctrl

Interface
REQ-001 The block SHALL have parameter REG_RESET_VAL, default 8'h00, the reset value of every general register.
REQ-002 The block SHALL have port clk, input, 1, the single rising-edge clock.
REQ-003 The block SHALL have port rst, input, 1, a synchronous active-high reset.
REQ-004 The block SHALL have port instr_valid, input, 1, meaning an instruction is offered.
REQ-005 The block SHALL have port instr_ready, output, 1, meaning the block can accept an instruction.
REQ-006 The block SHALL have port instr_op, input, 3, the ALU opcode (000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 NOT, 110 PASSB, 111 INC).
REQ-007 The block SHALL have port instr_rd, input, 2, the destination register and A-operand source.
REQ-008 The block SHALL have port instr_rs, input, 2, the B-operand source register.
REQ-009 The block SHALL have port instr_imm_sel, input, 1, which selects instr_imm as B instead of reg[rs] when 1.
REQ-010 The block SHALL have port instr_imm, input, 8, the immediate B operand.
REQ-011 The block SHALL have ports alu_a, alu_b and alu_op, outputs, 8/8/3, registered operands and opcode driven to the downstream combinational ALU.
REQ-012 The block SHALL have port alu_result, input, 8, the ALU output, sampled in EXEC.
REQ-013 The block SHALL have port done, output, 1, a one-cycle pulse on writeback completion.
REQ-014 The block SHALL have ports flag_z and flag_n, outputs, 1 each, the zero and negative flags of the last result.
REQ-015 The block SHALL have ports dbg_sel (input, 2) and dbg_data (output, 8), a combinational read of reg[dbg_sel].

Function
REQ-016 The block SHALL hold four 8-bit registers r0-r3.
REQ-017 The FSM SHALL have exactly three states: IDLE, EXEC and DONE.
REQ-018 instr_ready SHALL be 1 only in IDLE and not in reset.
REQ-019 Accept SHALL occur on an edge where IDLE, instr_valid=1 and instr_ready=1 hold.
- Latch alu_a=reg[rd], alu_b=(imm_sel ? imm : reg[rs]), alu_op=op, and latch rd.
- Go to EXEC.
REQ-020 In EXEC, the block SHALL write alu_result into reg[latched rd] on the next edge, set done=1 and go to DONE.
REQ-021 In DONE, the block SHALL go to IDLE on the next edge with done=0, so done is high exactly one cycle.
REQ-022 Latency SHALL be as follows:
- Accept at edge N.
- Register write and done rising at edge N+1.
- instr_ready high again after edge N+2.
- Throughput is one instruction per 3 cycles.
REQ-023 instr_valid and payload SHALL be ignored while not IDLE; the offered instruction stays pending until accepted.
REQ-024 When rd==rs, both operands SHALL use the same pre-write value; no bypass is needed because writes complete before the next accept.
REQ-025 alu_a, alu_b and alu_op SHALL hold their last values between instructions.
REQ-026 Arithmetic SHALL be modulo 256; the ALU carry is not observed, so wrap-around results are written as-is (e.g. FF+01 -> 00).
REQ-027 dbg_data SHALL reflect a write in the cycle after the write edge.

Reset
REQ-028 When rst=1 at an edge, the block SHALL take these values, overriding any state including mid-EXEC:
- State IDLE.
- r0-r3=REG_RESET_VAL.
- alu_a=alu_b=0, alu_op=000.
- done=0, flag_z=0, flag_n=0.
- No write.
REQ-029 instr_ready SHALL be 0 while rst=1 and 1 in the first cycle after rst deasserts.

Configuration
REQ-030 With macro ALU_EXEC_FLAGS_EN defined, the EXEC writeback edge SHALL also set flag_z=(alu_result==0) and flag_n=alu_result[7], held until the next writeback or reset.
REQ-031 Without ALU_EXEC_FLAGS_EN, flag_z and flag_n SHALL be tied to constant 0, and the ports SHALL remain present.

Verification
REQ-032 Reset then release -> dbg_data=00 for all sel; instr_ready=1 on the cycle after release; done=0.
REQ-033 Accept PASSB imm 8'h05 rd=r1, then ADD rd=r1 rs=r1 -> r1=05 then 0A; done pulses once per instruction, 3 cycles apart.
REQ-034 r2=00, SUB imm 01 rd=r2 -> r2=FF; with FLAGS_EN, flag_n=1 and flag_z=0.
REQ-035 Hold instr_valid=1 with changing payload during EXEC/DONE -> only the accepted instruction executes; the next is accepted in IDLE.
REQ-036 Assert rst in EXEC of INC r3 -> r3 stays REG_RESET_VAL, done never pulses, state IDLE.
REQ-037 Build without ALU_EXEC_FLAGS_EN, execute XOR r0,r0 (result 00) -> flag_z=0 and flag_n=0 throughout.
